keccak_string_to_array: RTL and testbench

Registered Keccak state-layout converter for the SHA-3 datapath. Accepts the flat 1600-bit state string S and presents it as the 5×5 array of 64-bit lanes A[x][y], using the FIPS 202 mapping. Sits between the absorb/XOR stage and the round-function input. Output is registered with a one-cycle valid strobe.

---
 rtl/keccak_pkg.sv | 21 ++
 rtl/sta_map.sv | 20 ++
 rtl/keccak_string_to_array.sv | 35 +++
 tb/tb_keccak_string_to_array.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared Keccak state-layout definitions: lane width, state width, lane/array types
// and the string-position of each lane's first bit.
`timescale 1ns/1ps
package keccak_pkg;

    localparam int LANE_W  = 64;
    localparam int STATE_W = 25 * LANE_W;

    typedef logic [LANE_W-1:0] lane_t;
    typedef lane_t [4:0][4:0]  state_arr_t;

    // Width-explicit form lets parameterised users (e.g. LANE_W=8 builds) share the formula.
    function automatic int lane_base_w(input int x, input int y, input int w);
        return w * (5 * y + x);
    endfunction

    function automatic int lane_base(input int x, input int y);
        return lane_base_w(x, y, LANE_W);
    endfunction

endpackage

// File: rtl/sta_map.sv
// Combinational Keccak string-to-array permutation: A[x][y][z] = S[w*(5y+x)+z].
// Pure wiring; reused by the inverse converter and the round logic.
`timescale 1ns/1ps
module sta_map #(
    parameter int LANE_W = keccak_pkg::LANE_W
) (
    input  logic [25*LANE_W-1:0]         S,
    output logic [4:0][4:0][LANE_W-1:0]  A
);
    import keccak_pkg::*;

    for (genvar gx = 0; gx < 5; gx++) begin : g_x
        for (genvar gy = 0; gy < 5; gy++) begin : g_y
            for (genvar gz = 0; gz < LANE_W; gz++) begin : g_z
                assign A[gx][gy][gz] = S[lane_base_w(gx, gy, LANE_W) + gz];
            end
        end
    end

endmodule

// File: rtl/keccak_string_to_array.sv
// Registered string-to-array converter: captures map(S) on in_valid and raises
// out_valid for exactly one cycle per capture.
`timescale 1ns/1ps
module keccak_string_to_array #(
    parameter int LANE_W = keccak_pkg::LANE_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [25*LANE_W-1:0]         S,
    output logic                         out_valid,
    output logic [4:0][4:0][LANE_W-1:0]  A
);

    logic [4:0][4:0][LANE_W-1:0] a_next;

    sta_map #(.LANE_W(LANE_W)) u_sta_map (
        .S (S),
        .A (a_next)
    );

    // A only loads on in_valid, so undriven S between transfers never reaches the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                A <= a_next;
            end
        end
    end

endmodule

// File: tb/tb_keccak_string_to_array.sv
// Self-checking bench for keccak_string_to_array (LANE_W=64 plus a LANE_W=8 instance).
`timescale 1ns/1ps
module tb_keccak_string_to_array;

    typedef logic [4:0][4:0][63:0] arr_t;
    typedef logic [4:0][4:0][7:0]  arr8_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic [1599:0] S = '0;
    logic         out_valid;
    arr_t         A;
    logic [199:0] S8 = '0;
    logic         out_valid8;
    arr8_t        A8;

    int   errors = 0;
    int   checks = 0;
    arr_t sb[$];
    arr_t held = '0;

    always #5 clk = ~clk;

    keccak_string_to_array #(.LANE_W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .S         (S),
        .out_valid (out_valid),
        .A         (A)
    );

    keccak_string_to_array #(.LANE_W(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .S         (S8),
        .out_valid (out_valid8),
        .A         (A8)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic check_lane(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reports the first differing lane so the line stays short.
    task automatic check_arr(input string tag, input arr_t obs, input arr_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    if (obs[x][y] !== exp[x][y]) begin
                        $error("FAIL %s: A[%0d][%0d] got %h want %h", tag, x, y, obs[x][y], exp[x][y]);
                        return;
                    end
        end
    endtask

    task automatic check_arr8(input string tag, input arr8_t obs, input arr8_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle from posedge+1; the result is checked at the next posedge+1.
    task automatic step(input string tag, input logic v, input logic [1599:0] s, input arr_t exp);
        arr_t e;
        in_valid = v;
        S        = s;
        if (v) sb.push_back(exp);
        @(posedge clk);
        #1;
        check_bit({tag, "_valid"}, out_valid, v);
        if (v) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_sb: scoreboard empty, got A[0][0]=%h want an entry", tag, A[0][0]);
            end else begin
                e = sb.pop_front();
                check_arr(tag, A, e);
                held = e;
            end
        end else begin
            check_arr({tag, "_held"}, A, held);
        end
    endtask

    initial begin
        logic [1599:0] one;
        logic [1599:0] s;
        logic [199:0]  one8;
        arr_t          e;
        arr_t          rep;
        arr_t          lane_idx;
        arr8_t         e8;
        int            cx, cy, cz;

        one  = 1;
        one8 = 1;
        rep  = {25{64'h0123_4567_89ab_cdef}};

        // Reset asserted with live input: must clear without any clock edge.
        S        = {25{64'hdead_beef_cafe_f00d}};
        S8       = '1;
        in_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_bit("rst_imm_valid", out_valid, 1'b0);
        check_arr("rst_imm_A", A, '0);
        check_arr8("rst_imm_A8", A8, '0);
        repeat (3) @(posedge clk);
        #1;
        check_bit("rst_held_valid", out_valid, 1'b0);
        check_arr("rst_held_A", A, '0);
        @(negedge clk);
        in_valid = 1'b0;
        S8       = '0;
        rst_n    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_bit("idle_valid", out_valid, 1'b0);
        check_arr("idle_A", A, '0);

        // Repeating pattern, then hold with X on S.
        step("repeat", 1'b1, {25{64'h0123_4567_89ab_cdef}}, rep);
        step("repeat_x", 1'b0, 'x, '0);

        // One-hot spot checks with hand-written targets.
        e = '0; e[0][0] = 64'h1;
        step("onehot_0", 1'b1, one << 0, e);
        e = '0; e[1][0] = 64'h1;
        step("onehot_64", 1'b1, one << 64, e);
        e = '0; e[0][1] = 64'h1;
        step("onehot_320", 1'b1, one << 320, e);
        e = '0; e[4][4] = 64'h8000_0000_0000_0000;
        step("onehot_1599", 1'b1, one << 1599, e);

        // Full sweep with target coordinates derived arithmetically from i.
        for (int i = 0; i < 1600; i++) begin
            cx = (i / 64) % 5;
            cy = i / 320;
            cz = i % 64;
            e = '0;
            e[cx][cy][cz] = 1'b1;
            step("sweep", 1'b1, one << i, e);
        end

        // Lane k holds the value k.
        s = '0;
        for (int k = 0; k < 25; k++) s[64*k +: 64] = 64'(k);
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                lane_idx[x][y] = 64'(5 * y + x);
        step("lane_idx", 1'b1, s, lane_idx);
        check_lane("lane_idx_A32", A[3][2], 64'd13);
        check_lane("lane_idx_A44", A[4][4], 64'd24);

        // Three back-to-back states, then idle.
        step("stream_0", 1'b1, '1, '1);
        step("stream_1", 1'b1, {800{2'b10}}, {100{16'haaaa}});
        step("stream_2", 1'b1, s, lane_idx);
        step("stream_end", 1'b0, '0, '0);

        // Async reset between edges while a capture is pending.
        in_valid = 1'b1;
        S        = '1;
        sb.push_back('1);
        #3 rst_n = 1'b0;
        #1;
        check_bit("midrst_valid", out_valid, 1'b0);
        check_arr("midrst_A", A, '0);
        sb.delete();
        held = '0;
        @(posedge clk);
        #1;
        check_bit("midrst_held_valid", out_valid, 1'b0);
        check_arr("midrst_held_A", A, '0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        step("post_rst", 1'b1, s, lane_idx);

        // LANE_W=8 instance: zero state, then one-hot bit 47 lands in lane (0,1) bit 7.
        S8 = '0;
        step("w8_zero", 1'b1, '0, '0);
        check_arr8("w8_zero_A8", A8, '0);
        S8 = one8 << 47;
        step("w8_bit47", 1'b1, '0, '0);
        e8 = '0; e8[0][1] = 8'h80;
        check_bit("w8_bit47_valid8", out_valid8, 1'b1);
        check_arr8("w8_bit47_A8", A8, e8);
        step("w8_end", 1'b0, '0, '0);
        check_bit("w8_end_valid8", out_valid8, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
